thor2023_regfile_wrsched: RTL and testbench

Write-port scheduler for the Thor2023 register file. It shares the file's single write port (`wr`/`wa`/`i`) between up to NREQ result producers (ALU, FPU, load unit, ...) and one group-write requester. A group write delivers an octa value as four consecutive register writes. The block sits between the execute/writeback stage and the register file and drives the file's write port from registers only.

---
 rtl/thor2023_regfile_wrsched_if.sv | 29 ++
 rtl/thor2023_regfile_wrsched.sv | 136 +++++++++++++
 tb/tb_thor2023_regfile_wrsched.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/thor2023_regfile_wrsched_if.sv
// rtl/thor2023_regfile_wrsched_if.sv - requester and regfile write-port bundle for the write scheduler
interface thor2023_regfile_wrsched_if #(
  parameter int NREQ = 3,
  parameter int DW   = 128,
  parameter int AW   = 7
);
  logic [NREQ-1:0]    req_v;
  logic [NREQ*AW-1:0] req_wa;
  logic [NREQ*DW-1:0] req_d;
  logic [NREQ-1:0]    req_rdy;
  logic               grp_v;
  logic [3:0]         grp_base;
  logic [4*DW-1:0]    grp_d;
  logic               grp_rdy;
  logic               wr;
  logic [AW-1:0]      wa;
  logic [DW-1:0]      i;
  logic               busy;

  modport master (
    output req_v, req_wa, req_d, grp_v, grp_base, grp_d,
    input  req_rdy, grp_rdy, wr, wa, i, busy
  );

  modport slave (
    input  req_v, req_wa, req_d, grp_v, grp_base, grp_d,
    output req_rdy, grp_rdy, wr, wa, i, busy
  );
endinterface

// File: rtl/thor2023_regfile_wrsched.sv
// rtl/thor2023_regfile_wrsched.sv - round-robin scheduler sharing the regfile write port
// Singles write in one beat; a group write streams four lanes from a holding register.
module thor2023_regfile_wrsched #(
  parameter int NREQ = 3,
  parameter int DW   = 128,
  parameter int AW   = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  thor2023_regfile_wrsched_if.slave bus
);
  localparam int NS = NREQ + 1;
  localparam int PW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic {S_IDLE, S_GROUP} state_t;

  state_t          state;
  logic [1:0]      beat;
  logic [PW-1:0]   ptr;
  logic [3:0]      hold_base;
  logic [3*DW-1:0] hold_d;
  logic            wr_q;
  logic [AW-1:0]   wa_q;
  logic [DW-1:0]   i_q;
  logic            busy_q;

  logic [NS-1:0]   reqs;
  logic [NS-1:0]   rot;
  logic [PW-1:0]   off;
  logic [PW:0]     sum;
  logic [PW-1:0]   win;
  logic            win_found;
  logic            arb_en;
  logic            gnt_v;
  logic            grp_gnt;
  logic            sgl_gnt;
  logic [NREQ-1:0] rdy_c;
  logic [AW-1:0]   sel_wa;
  logic [DW-1:0]   sel_d;
  logic [1:0]      nxt;
  logic [DW-1:0]   lane_d;

  assign reqs = {bus.grp_v, bus.req_v};

  // Rotate requests so bit 0 is the slot at ptr; the lowest set bit is the winner.
  always_comb begin
    rot       = NS'({reqs, reqs} >> ptr);
    win_found = |rot;
    off       = '0;
    for (int j = NS - 1; j >= 0; j--) begin
      if (rot[j]) off = PW'(j);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    win = (sum >= (PW+1)'(NS)) ? PW'(sum - (PW+1)'(NS)) : PW'(sum);
  end

  // Lane 3 is on the port during beat 3, so the next grant lands without a bubble.
  assign arb_en  = !rst && ((state == S_IDLE) || (beat == 2'd3));
  assign gnt_v   = arb_en && win_found;
  assign grp_gnt = gnt_v && (win == PW'(NREQ));
  assign sgl_gnt = gnt_v && !grp_gnt;

  always_comb begin
    rdy_c  = '0;
    sel_wa = '0;
    sel_d  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == PW'(k)) begin
        rdy_c[k] = sgl_gnt;
        sel_wa   = bus.req_wa[k*AW +: AW];
        sel_d    = bus.req_d[k*DW +: DW];
      end
    end
  end

  always_comb begin
    nxt    = beat + 2'd1;
    lane_d = '0;
    for (int n = 1; n < 4; n++) begin
      if (nxt == 2'(n)) lane_d = hold_d[(n-1)*DW +: DW];
    end
  end

  assign bus.req_rdy = rdy_c;
  assign bus.grp_rdy = grp_gnt;
  assign bus.wr      = wr_q;
  assign bus.wa      = wa_q;
  assign bus.i       = i_q;
  assign bus.busy    = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      beat      <= 2'd0;
      ptr       <= '0;
      hold_base <= 4'd0;
      hold_d    <= '0;
      wr_q      <= 1'b0;
      wa_q      <= '0;
      i_q       <= '0;
      busy_q    <= 1'b0;
    end else begin
      if (gnt_v) ptr <= grp_gnt ? '0 : win + PW'(1);

      if (sgl_gnt) begin
        wr_q   <= |sel_wa[5:0];
        wa_q   <= sel_wa;
        i_q    <= sel_d;
        state  <= S_IDLE;
        beat   <= 2'd0;
        busy_q <= 1'b0;
      end else if (grp_gnt) begin
        // Lane 0 goes straight out; lanes 1..3 wait in the holding register.
        wr_q      <= |bus.grp_base;
        wa_q      <= AW'({bus.grp_base, 2'b00});
        i_q       <= bus.grp_d[DW-1:0];
        hold_base <= bus.grp_base;
        hold_d    <= bus.grp_d[4*DW-1:DW];
        state     <= S_GROUP;
        beat      <= 2'd0;
        busy_q    <= 1'b1;
      end else if (state == S_GROUP && beat != 2'd3) begin
        wr_q   <= 1'b1;
        wa_q   <= AW'({hold_base, nxt});
        i_q    <= lane_d;
        beat   <= nxt;
        busy_q <= 1'b1;
      end else begin
        wr_q   <= 1'b0;
        state  <= S_IDLE;
        beat   <= 2'd0;
        busy_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_thor2023_regfile_wrsched.sv
// tb/tb_thor2023_regfile_wrsched.sv - vector table, corner sequences and random run against a queue model
module tb_thor2023_regfile_wrsched;
  localparam int NREQ = 3;
  localparam int DW   = 128;
  localparam int AW   = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  thor2023_regfile_wrsched_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

  thor2023_regfile_wrsched #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [2:0]   rv;
    logic [6:0]   wa;
    logic [127:0] d;
    logic         gv;
    logic [3:0]   gb;
    logic [2:0]   erdy;
    logic         egrdy;
    logic         ewr;
    logic [6:0]   ewa;
    logic [127:0] ei;
  } vec_t;

  typedef struct {
    logic         wr;
    logic [6:0]   wa;
    logic [127:0] d;
    logic         grp;
  } wr_t;

  // Future port contents, one entry per cycle; grants only when nothing is pending.
  wr_t          m_q[$];
  int           m_ptr;
  logic         e_wr, e_busy;
  logic [6:0]   e_wa;
  logic [127:0] e_i;
  logic [2:0]   s_rdy;
  logic         s_grdy;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ptr  = 0;
    e_wr   = 1'b0;
    e_busy = 1'b0;
    e_wa   = '0;
    e_i    = '0;
  endtask

  task automatic model_eval(output int win);
    int  s;
    logic r;
    win = -1;
    if (m_q.size() == 0 && !rst) begin
      for (int j = 0; j <= NREQ; j++) begin
        s = (m_ptr + j) % (NREQ + 1);
        r = (s < NREQ) ? bus.req_v[s] : bus.grp_v;
        if (r && win < 0) win = s;
      end
    end
  endtask

  task automatic model_commit(input int win);
    logic [6:0] a;
    wr_t        e;
    if (win >= 0 && win < NREQ) begin
      a = bus.req_wa[win*AW +: AW];
      m_q.push_back('{a[5:0] != 6'd0, a, bus.req_d[win*DW +: DW], 1'b0});
      m_ptr = win + 1;
    end else if (win == NREQ) begin
      for (int n = 0; n < 4; n++) begin
        a = {1'b0, bus.grp_base, 2'(n)};
        m_q.push_back('{a[5:0] != 6'd0, a, bus.grp_d[n*DW +: DW], 1'b1});
      end
      m_ptr = 0;
    end
    if (m_q.size() > 0) begin
      e      = m_q.pop_front();
      e_wr   = e.wr;
      e_wa   = e.wa;
      e_i    = e.d;
      e_busy = e.grp;
    end else begin
      e_wr   = 1'b0;
      e_busy = 1'b0;
    end
  endtask

  task automatic cycle_chk();
    int         win;
    logic [2:0] erdy;
    #1;
    model_eval(win);
    erdy   = (win >= 0 && win < NREQ) ? 3'(1 << win) : 3'b000;
    s_rdy  = bus.req_rdy;
    s_grdy = bus.grp_rdy;
    check("req_rdy", s_rdy, erdy);
    check("grp_rdy", s_grdy, win == NREQ);
    @(posedge clk);
    model_commit(win);
    #1;
    check("wr", bus.wr, e_wr);
    if (e_wr) begin
      check("wa", bus.wa, e_wa);
      check("i", bus.i, e_i);
    end
    check("busy", bus.busy, e_busy);
    @(negedge clk);
  endtask

  task automatic set_singles(input logic [2:0] rv, input logic [6:0] wa, input logic [127:0] d);
    bus.req_v = rv;
    for (int k = 0; k < NREQ; k++) begin
      bus.req_wa[k*AW +: AW] = wa + 7'(k);
      bus.req_d[k*DW +: DW]  = d + 128'(k);
    end
  endtask

  task automatic set_group(input logic gv, input logic [3:0] base, input logic [127:0] d);
    bus.grp_v    = gv;
    bus.grp_base = base;
    for (int n = 0; n < 4; n++) bus.grp_d[n*DW +: DW] = d + 128'(n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_singles(3'b000, 7'd0, '0);
    set_group(1'b0, 4'd0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  vec_t tbl[8];
  int   exp_code[8];
  int   code;

  initial begin
    tbl[0] = '{3'b010, 7'd4,  128'h1233,      1'b0, 4'd0, 3'b010, 1'b0, 1'b1, 7'd5,  128'h1234};
    tbl[1] = '{3'b001, 7'd0,  128'habcd,      1'b0, 4'd0, 3'b001, 1'b0, 1'b0, 7'd0,  128'h0};
    tbl[2] = '{3'b100, 7'h3e, 128'h55,        1'b0, 4'd0, 3'b100, 1'b0, 1'b0, 7'd0,  128'h0};
    tbl[3] = '{3'b111, 7'h11, 128'hdeadbeef,  1'b0, 4'd0, 3'b001, 1'b0, 1'b1, 7'h11, 128'hdeadbeef};
    tbl[4] = '{3'b110, 7'h20, 128'h7,         1'b0, 4'd0, 3'b010, 1'b0, 1'b1, 7'h21, 128'h8};
    tbl[5] = '{3'b000, 7'h0,  128'h99,        1'b1, 4'd5, 3'b000, 1'b1, 1'b1, 7'd20, 128'h99};
    tbl[6] = '{3'b010, 7'h30, 128'h1,         1'b1, 4'd2, 3'b010, 1'b0, 1'b1, 7'h31, 128'h2};
    tbl[7] = '{3'b000, 7'h0,  128'h0,         1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 7'd0,  128'h0};
    exp_code = '{0, 1, 2, 3, 7, 7, 7, 0};

    // Reset with every valid high
    rst = 1'b1;
    set_singles(3'b111, 7'h11, 128'h77);
    set_group(1'b1, 4'd6, 128'h88);
    @(negedge clk);
    #1;
    check("rst_req_rdy", bus.req_rdy, 3'b000);
    check("rst_grp_rdy", bus.grp_rdy, 1'b0);
    check("rst_wr", bus.wr, 1'b0);
    check("rst_wa", bus.wa, 7'd0);
    check("rst_i", bus.i, 128'h0);
    check("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    set_singles(3'b000, 7'd0, '0);
    set_group(1'b0, 4'd0, '0);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      cycle_chk();
      check("idle_wr", bus.wr, 1'b0);
    end

    // Vector table, one grant from reset each
    for (int v = 0; v < 8; v++) begin
      do_reset();
      set_singles(tbl[v].rv, tbl[v].wa, tbl[v].d);
      set_group(tbl[v].gv, tbl[v].gb, tbl[v].d);
      #1;
      check($sformatf("vec%0d_rdy", v), bus.req_rdy, tbl[v].erdy);
      check($sformatf("vec%0d_grdy", v), bus.grp_rdy, tbl[v].egrdy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_wr", v), bus.wr, tbl[v].ewr);
      if (tbl[v].ewr) begin
        check($sformatf("vec%0d_wa", v), bus.wa, tbl[v].ewa);
        check($sformatf("vec%0d_i", v), bus.i, tbl[v].ei);
      end
      @(negedge clk);
    end

    // Single to requester 1 moves the pointer to 2
    do_reset();
    set_singles(3'b010, 7'd4, 128'h1233);
    cycle_chk();
    check("single_wa", bus.wa, 7'd5);
    set_singles(3'b111, 7'h40, 128'h5);
    cycle_chk();
    check("ptr2_rdy", s_rdy, 3'b100);

    // Round-robin with everything requesting from reset
    do_reset();
    set_singles(3'b111, 7'h10, 128'h100);
    set_group(1'b1, 4'd7, 128'h200);
    for (int c = 0; c < 8; c++) begin
      cycle_chk();
      code = s_grdy ? 3 : (s_rdy == 3'b001) ? 0 : (s_rdy == 3'b010) ? 1 : (s_rdy == 3'b100) ? 2 : 7;
      check($sformatf("rr_order%0d", c), code, exp_code[c]);
      check($sformatf("rr_nogap%0d", c), bus.wr, 1'b1);
    end

    // Group at base 3
    do_reset();
    set_group(1'b1, 4'd3, 128'ha0);
    cycle_chk();
    set_group(1'b0, 4'd0, '0);
    for (int n = 0; n < 4; n++) begin
      check($sformatf("g3_wr%0d", n), bus.wr, 1'b1);
      check($sformatf("g3_wa%0d", n), bus.wa, 7'(12 + n));
      check($sformatf("g3_i%0d", n), bus.i, 128'ha0 + 128'(n));
      check($sformatf("g3_busy%0d", n), bus.busy, 1'b1);
      cycle_chk();
    end
    check("g3_busy_end", bus.busy, 1'b0);
    check("g3_wr_end", bus.wr, 1'b0);

    // Group at base 0: lane 0 suppressed
    do_reset();
    set_group(1'b1, 4'd0, 128'hb0);
    cycle_chk();
    set_group(1'b0, 4'd0, '0);
    for (int n = 0; n < 4; n++) begin
      check($sformatf("g0_wr%0d", n), bus.wr, n != 0);
      if (n != 0) check($sformatf("g0_wa%0d", n), bus.wa, 7'(n));
      cycle_chk();
    end

    // Reset during beat 1
    do_reset();
    set_group(1'b1, 4'd9, 128'hc0);
    cycle_chk();
    set_group(1'b0, 4'd0, '0);
    cycle_chk();
    check("mid_wa_beat1", bus.wa, 7'd37);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_wr", bus.wr, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle_chk();
      check($sformatf("mid_after_wr%0d", c), bus.wr, 1'b0);
    end
    set_singles(3'b111, 7'h22, 128'h3);
    cycle_chk();
    check("mid_ptr0_rdy", s_rdy, 3'b001);

    // Random traffic against the queue model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bus.req_v = 3'($urandom);
      for (int k = 0; k < NREQ; k++) begin
        bus.req_wa[k*AW +: AW] = ($urandom % 8 == 0) ? {1'($urandom), 6'd0} : 7'($urandom);
        bus.req_d[k*DW +: DW]  = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.grp_v    = ($urandom % 4 == 0);
      bus.grp_base = ($urandom % 6 == 0) ? 4'd0 : 4'($urandom);
      for (int n = 0; n < 4; n++) bus.grp_d[n*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
      cycle_chk();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
